// File: rtl/matrix_stream_loader_if.sv
// Handshake and operand bus between the element stream, the loader and the
// matrix multiplier. The slave modport is the loader; the master is its environment.
interface matrix_stream_loader_if #(
    parameter int n  = 4,
    parameter int CW = $clog2(n*n+1)
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic              flush;
    logic              mat_ack;
    logic [32*n*n:0]   matrix_A;
    logic [32*n*n:0]   matrix_B;
    logic              mat_valid;
    logic              loading_b;
    logic [CW-1:0]     elem_count;

    modport master (
        output in_valid, in_data, flush, mat_ack,
        input  in_ready, matrix_A, matrix_B, mat_valid, loading_b, elem_count
    );

    modport slave (
        input  in_valid, in_data, flush, mat_ack,
        output in_ready, matrix_A, matrix_B, mat_valid, loading_b, elem_count
    );
endinterface

// File: rtl/matrix_stream_loader.sv
// Assembles a serial element stream row-major into matrix A then matrix B and
// holds the pair stable for the multiplier until it is acknowledged.
module matrix_stream_loader #(
    parameter int n  = 4,
    parameter int CW = $clog2(n*n+1)
) (
    input  logic                 clk,
    input  logic                 rst,
    matrix_stream_loader_if.slave bus
);
    localparam int            SLOTS = n*n;
    localparam int            BW    = 32*SLOTS;
    localparam logic [CW-1:0] LAST  = CW'(SLOTS-1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        FULL   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [BW-1:0]   mat_a_q, mat_a_d;
    logic [BW-1:0]   mat_b_q, mat_b_d;
    logic            mat_valid_q, mat_valid_d;
    logic            accept;

    always_comb begin
        // NOTE: every value written here gets a default first, so no path can
        // leave a signal unassigned and infer a latch.
        state_d = state_q;
        count_d = count_q;
        mat_a_d = mat_a_q;
        mat_b_d = mat_b_q;
        accept  = bus.in_valid && (state_q != FULL) && !bus.flush;

        // Flush outranks both a concurrent transfer and an acknowledge.
        if (bus.flush) begin
            state_d = LOAD_A;
            count_d = '0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (accept) begin
                        mat_a_d[32*int'(count_q) +: 32] = bus.in_data;
                        if (count_q == LAST) begin
                            count_d = '0;
                            state_d = LOAD_B;
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        mat_b_d[32*int'(count_q) +: 32] = bus.in_data;
                        if (count_q == LAST) begin
                            count_d = '0;
                            state_d = FULL;
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                    end
                end
                FULL: begin
                    if (bus.mat_ack) begin
                        state_d = LOAD_A;
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = LOAD_A;
                    count_d = '0;
                end
            endcase
        end

        mat_valid_d = (state_d == FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD_A;
            count_q     <= '0;
            // NOTE: the operand buses are plain flops, not a RAM, and the
            // multiplier may observe them at any time, so they take a reset value.
            mat_a_q     <= '0;
            mat_b_q     <= '0;
            mat_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above.
            state_q     <= state_d;
            count_q     <= count_d;
            mat_a_q     <= mat_a_d;
            mat_b_q     <= mat_b_d;
            mat_valid_q <= mat_valid_d;
        end
    end

    assign bus.in_ready   = (state_q != FULL);
    assign bus.loading_b  = (state_q == LOAD_B);
    assign bus.mat_valid  = mat_valid_q;
    assign bus.elem_count = count_q;
    assign bus.matrix_A   = {1'b0, mat_a_q};
    assign bus.matrix_B   = {1'b0, mat_b_q};
endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader: an element-array model checked every
// cycle, plus literal expectations taken from the hand-worked scenarios.
module tb_matrix_stream_loader;
    localparam int N     = 4;
    localparam int SLOTS = N*N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matrix_stream_loader_if #(.n(N)) bus ();

    matrix_stream_loader #(.n(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: element arrays plus phase (0 = A, 1 = B, 2 = full) and count.
    int unsigned m_a [SLOTS];
    int unsigned m_b [SLOTS];
    int          m_phase = 0;
    int          m_cnt   = 0;

    initial begin
        for (int i = 0; i < SLOTS; i++) begin
            m_a[i] = 0;
            m_b[i] = 0;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_cnt   = 0;
            for (int i = 0; i < SLOTS; i++) begin
                m_a[i] = 0;
                m_b[i] = 0;
            end
        end else if (bus.flush) begin
            m_phase = 0;
            m_cnt   = 0;
        end else if (m_phase == 2) begin
            if (bus.mat_ack) m_phase = 0;
        end else if (bus.in_valid) begin
            if (m_phase == 0) m_a[m_cnt] = bus.in_data;
            else              m_b[m_cnt] = bus.in_data;
            m_cnt++;
            if (m_cnt == SLOTS) begin
                m_cnt = 0;
                m_phase++;
            end
        end
    end

    function automatic logic [519:0] pack_bus(input int unsigned arr [SLOTS]);
        logic [519:0] r;
        r = '0;
        for (int i = 0; i < SLOTS; i++) r[i*32 +: 32] = arr[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [519:0] act, input logic [519:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("mat_valid",  520'(bus.mat_valid),  520'(m_phase == 2));
        check("in_ready",   520'(bus.in_ready),   520'(m_phase != 2));
        check("loading_b",  520'(bus.loading_b),  520'(m_phase == 1));
        check("elem_count", 520'(bus.elem_count), 520'(m_cnt));
        check("matrix_A",   520'(bus.matrix_A),   pack_bus(m_a));
        check("matrix_B",   520'(bus.matrix_B),   pack_bus(m_b));
    end

    task automatic step(input logic v, input logic [31:0] d, input logic f, input logic a);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.flush    = f;
        bus.mat_ack  = a;
        @(negedge clk);
    endtask

    initial begin
        int accepted;
        int k;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.flush    = 1'b0;
        bus.mat_ack  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst mat_valid",  520'(bus.mat_valid),  520'(0));
        check("rst in_ready",   520'(bus.in_ready),   520'(1));
        check("rst loading_b",  520'(bus.loading_b),  520'(0));
        check("rst elem_count", 520'(bus.elem_count), 520'(0));
        check("rst matrix_A",   520'(bus.matrix_A),   520'(0));

        // Back-to-back load of 1..32
        for (int i = 1; i <= 32; i++) begin
            step(1'b1, 32'(i), 1'b0, 1'b0);
            if (i == 15) check("lb before 16", 520'(bus.loading_b), 520'(0));
            if (i == 16) check("lb after 16",  520'(bus.loading_b), 520'(1));
        end
        check("load mat_valid", 520'(bus.mat_valid),        520'(1));
        check("load in_ready",  520'(bus.in_ready),         520'(0));
        check("A[0]",           520'(bus.matrix_A[31:0]),   520'(1));
        check("A[15]",          520'(bus.matrix_A[511:480]),520'(16));
        check("B[0]",           520'(bus.matrix_B[31:0]),   520'(17));
        check("B[15]",          520'(bus.matrix_B[511:480]),520'(32));
        check("A top bit",      520'(bus.matrix_A[512]),    520'(0));
        check("B top bit",      520'(bus.matrix_B[512]),    520'(0));

        // FULL ignores input, then acknowledge
        for (int i = 0; i < 10; i++) step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        check("full hold mv", 520'(bus.mat_valid),      520'(1));
        check("full hold A0", 520'(bus.matrix_A[31:0]), 520'(1));
        check("full hold B0", 520'(bus.matrix_B[31:0]), 520'(17));
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("ack mat_valid",  520'(bus.mat_valid),  520'(0));
        check("ack in_ready",   520'(bus.in_ready),   520'(1));
        check("ack elem_count", 520'(bus.elem_count), 520'(0));
        check("ack loading_b",  520'(bus.loading_b),  520'(0));

        // 20 elements with gaps, then flush on a valid element
        accepted = 0;
        k = 0;
        while (accepted < 20 && k < 100) begin
            if (k % 3 == 1) step(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
            else begin
                step(1'b1, 32'(200 + accepted), 1'b0, 1'b0);
                accepted++;
            end
            k++;
        end
        check("gap count", 520'(bus.elem_count), 520'(4));
        step(1'b1, 32'h0BAD_0BAD, 1'b1, 1'b0);
        check("flush elem_count", 520'(bus.elem_count),       520'(0));
        check("flush loading_b",  520'(bus.loading_b),        520'(0));
        check("flush B[4] kept",  520'(bus.matrix_B[159:128]),520'(21));
        check("flush A[0] kept",  520'(bus.matrix_A[31:0]),   520'(200));

        // Fresh load 100..131: mat_valid after exactly 32 transfers
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 32'(100 + i), 1'b0, 1'b0);
            if (i == 30) check("mv after 31", 520'(bus.mat_valid), 520'(0));
            if (i == 31) check("mv after 32", 520'(bus.mat_valid), 520'(1));
        end
        check("fresh A[0]", 520'(bus.matrix_A[31:0]), 520'(100));
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // mat_ack in LOAD_A is ignored
        for (int i = 0; i < 5; i++) step(1'b1, 32'(300 + i), 1'b0, 1'b0);
        check("cnt 5", 520'(bus.elem_count), 520'(5));
        step(1'b1, 32'd305, 1'b0, 1'b1);
        check("cnt 6 ack ign", 520'(bus.elem_count), 520'(6));
        step(1'b1, 32'd306, 1'b0, 1'b0);
        check("cnt 7", 520'(bus.elem_count), 520'(7));
        for (int i = 7; i < 20; i++) step(1'b1, 32'(300 + i), 1'b0, 1'b0);
        check("mid B lb",  520'(bus.loading_b),  520'(1));
        check("mid B cnt", 520'(bus.elem_count), 520'(4));

        // Asynchronous reset between edges
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst mat_valid",  520'(bus.mat_valid),  520'(0));
        check("arst in_ready",   520'(bus.in_ready),   520'(1));
        check("arst loading_b",  520'(bus.loading_b),  520'(0));
        check("arst elem_count", 520'(bus.elem_count), 520'(0));
        check("arst matrix_A",   520'(bus.matrix_A),   520'(0));
        check("arst matrix_B",   520'(bus.matrix_B),   520'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) step(1'b1, 32'(1000 + i), 1'b0, 1'b0);
        check("post rst mv",  520'(bus.mat_valid),         520'(1));
        check("post rst B15", 520'(bus.matrix_B[511:480]), 520'(1031));

        // flush and mat_ack together in FULL
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("fa mat_valid",  520'(bus.mat_valid),  520'(0));
        check("fa elem_count", 520'(bus.elem_count), 520'(0));
        check("fa in_ready",   520'(bus.in_ready),   520'(1));
        check("fa loading_b",  520'(bus.loading_b),  520'(0));
        step(1'b0, 32'h0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
